bcd_countdown999: RTL

Three-digit BCD down-counter, 999 to 000, with parallel load, start/stop control, a programmable tick prescaler and an optional auto-reload. It counts in the opposite direction to the team's 0–999 BCD up-counter and uses the same digit-output format (q1 = units, q2 = tens, q3 = hundreds). It serves as the countdown/timer engine for the display path. A terminal-count `done` pulse feeds downstream control.

---
 rtl/bcd_countdown999_if.sv | 25 ++
 rtl/bcd_countdown999.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/bcd_countdown999_if.sv
// Control and digit-output bundle of the three-digit BCD down-counter.
// The controller drives load/start/stop; the counter returns the
// digits and the status pulses.
interface bcd_countdown999_if;
    logic        load;
    logic [11:0] load_val;
    logic        start;
    logic        stop;
    logic [3:0]  q1;
    logic [3:0]  q2;
    logic [3:0]  q3;
    logic        busy;
    logic        done;
    logic        err;

    modport master (
        output load, load_val, start, stop,
        input  q1, q2, q3, busy, done, err
    );

    modport slave (
        input  load, load_val, start, stop,
        output q1, q2, q3, busy, done, err
    );
endinterface

// File: rtl/bcd_countdown999.sv
// Three-digit BCD down-counter (999..000) with parallel load, start/stop,
// tick prescaler and optional auto-reload. q1 = units, q2 = tens,
// q3 = hundreds. done pulses on the cycle the count reads 000; err pulses
// when a load is rejected for carrying a non-BCD digit.
module bcd_countdown999 #(
    parameter int TICK_DIV    = 1,
    parameter int AUTO_RELOAD = 0
) (
    input  logic                clk,
    input  logic                rst,
    bcd_countdown999_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, RUN, PAUSED, DONE} state_t;

    localparam logic [15:0] PRESC_MAX = 16'(TICK_DIV - 1);
    localparam bit          RELOAD_EN = (AUTO_RELOAD != 0);

    state_t      state_q;
    logic [11:0] cnt_q;
    logic [11:0] reload_q;
    logic [15:0] presc_q;
    logic        busy_q;
    logic        done_q;
    logic        err_q;

    logic [2:0]  digit_ok;
    logic        load_ok;
    logic [11:0] cnt_dec;

    // A load is only accepted when every nibble is a legal BCD digit.
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_digit_chk
            assign digit_ok[gi] = (bus.load_val[gi*4 +: 4] <= 4'd9);
        end
    endgenerate
    assign load_ok = &digit_ok;

    // BCD decrement with borrow ripple; only used when the count is non-zero,
    // so the hundreds digit never underflows.
    always_comb begin
        cnt_dec = cnt_q;
        if (cnt_q[3:0] != 4'd0) begin
            cnt_dec[3:0] = cnt_q[3:0] - 4'd1;
        end else begin
            cnt_dec[3:0] = 4'd9;
            if (cnt_q[7:4] != 4'd0) begin
                cnt_dec[7:4] = cnt_q[7:4] - 4'd1;
            end else begin
                cnt_dec[7:4]  = 4'd9;
                cnt_dec[11:8] = cnt_q[11:8] - 4'd1;
            end
        end
    end

    // Control FSM: priority rst > load > stop > start > tick.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            reload_q <= '0;
            presc_q  <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            if (bus.load) begin
                // A rejected load leaves everything untouched and swallows
                // any start/stop/tick in the same cycle.
                if (load_ok) begin
                    cnt_q    <= bus.load_val;
                    reload_q <= bus.load_val;
                    presc_q  <= '0;
                    state_q  <= IDLE;
                    busy_q   <= 1'b0;
                end else begin
                    err_q <= 1'b1;
                end
            end else if (bus.stop) begin
                if (state_q == RUN) begin
                    state_q <= PAUSED;
                    busy_q  <= 1'b0;
                end
            end else if (bus.start && (state_q != RUN)) begin
                case (state_q)
                    IDLE: begin
                        if (cnt_q != 12'd0) begin
                            state_q <= RUN;
                            busy_q  <= 1'b1;
                            presc_q <= '0;
                        end else begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end
                    end
                    PAUSED: begin
                        // Resume keeps the prescaler phase.
                        state_q <= RUN;
                        busy_q  <= 1'b1;
                    end
                    default: begin
                        cnt_q <= reload_q;
                        if (reload_q != 12'd0) begin
                            state_q <= RUN;
                            busy_q  <= 1'b1;
                            presc_q <= '0;
                        end else begin
                            done_q <= 1'b1;
                        end
                    end
                endcase
            end else if (state_q == RUN) begin
                if (presc_q == PRESC_MAX) begin
                    presc_q <= '0;
                    if (cnt_q == 12'd0) begin
                        // Only reachable with auto-reload: this tick restarts
                        // the count instead of decrementing.
                        if (RELOAD_EN && (reload_q != 12'd0)) begin
                            cnt_q <= reload_q;
                        end else begin
                            state_q <= DONE;
                            busy_q  <= 1'b0;
                        end
                    end else begin
                        cnt_q <= cnt_dec;
                        if (cnt_dec == 12'd0) begin
                            done_q <= 1'b1;
                            if (!RELOAD_EN || (reload_q == 12'd0)) begin
                                state_q <= DONE;
                                busy_q  <= 1'b0;
                            end
                        end
                    end
                end else begin
                    presc_q <= presc_q + 16'd1;
                end
            end
        end
    end

    assign bus.q1   = cnt_q[3:0];
    assign bus.q2   = cnt_q[7:4];
    assign bus.q3   = cnt_q[11:8];
    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.err  = err_q;
endmodule
